// File: rtl/sm3_pkg.sv
// Shared SM3 constants, FSM state type and per-bit boolean functions.
// The per-bit form lets any word width apply them with a simple bit loop.
package sm3_pkg;

  localparam logic [31:0] T_LO = 32'h79CC4519;
  localparam logic [31:0] T_HI = 32'h7A879D8A;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  // hi selects the late-round form (majority / choose).
  function automatic logic sm3_ff(input logic x, input logic y, input logic z, input logic hi);
    return hi ? ((x & y) | (x & z) | (y & z)) : (x ^ y ^ z);
  endfunction

  function automatic logic sm3_gg(input logic x, input logic y, input logic z, input logic hi);
    return hi ? ((x & y) | (~x & z)) : (x ^ y ^ z);
  endfunction

endpackage

// File: rtl/sm3_ffgg_core.sv
// Combinational FF_j / GG_j evaluation with out-of-range round detection.
// Results are forced to zero when j_used lies outside 0..ROUNDS-1.
module sm3_ffgg_core
  import sm3_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int SPLIT  = 16,
  parameter int J_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  input  logic [WORD_W-1:0] z,
  input  logic [J_W-1:0]    j_used,
  output logic [WORD_W-1:0] ff,
  output logic [WORD_W-1:0] gg,
  output logic              range_err
);

  logic hi;

  // NOTE: every output gets a default before any branch so no latch is inferred.
  always_comb begin
    ff        = '0;
    gg        = '0;
    range_err = (32'(j_used) >= ROUNDS);
    hi        = (32'(j_used) >= SPLIT);
    if (!range_err) begin
      for (int i = 0; i < WORD_W; i++) begin
        ff[i] = sm3_ff(x[i], y[i], z[i], hi);
        gg[i] = sm3_gg(x[i], y[i], z[i], hi);
      end
    end
  end

endmodule

// File: rtl/sm3_ffgg_stream.sv
// Streaming SM3 FF/GG stage: one registered output with valid/ready, manual or auto round index.
// Optional macro SM3_TJ_EN adds output_tj = rotl(T_j, j mod 32), WORD_W must be 32.
module sm3_ffgg_stream
  import sm3_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int SPLIT  = 16,
  parameter int J_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic              input_clk,
  input  logic              input_rst_n,
  input  logic              input_valid,
  output logic              output_ready,
  input  logic [WORD_W-1:0] input_X,
  input  logic [WORD_W-1:0] input_Y,
  input  logic [WORD_W-1:0] input_Z,
  input  logic [J_W-1:0]    input_j,
  input  logic              input_first,
  input  logic              input_auto_j,
  output logic              output_valid,
  input  logic              input_ready,
  output logic [WORD_W-1:0] output_ff,
  output logic [WORD_W-1:0] output_gg,
  output logic [J_W-1:0]    output_j,
  output logic              output_last,
  output logic              output_err
`ifdef SM3_TJ_EN
  ,
  output logic [WORD_W-1:0] output_tj
`endif
);

  if (SPLIT >= ROUNDS) begin : g_bad_split
    $error("sm3_ffgg_stream: SPLIT must be less than ROUNDS");
  end

  state_t            state_q, state_d;
  logic [J_W-1:0]    cnt_q, cnt_d, j_used;
  logic              mode_q, rdy_q;
  logic              auto_eff, accept, last_d, frame_err, range_err, err_d;
  logic [WORD_W-1:0] ff_d, gg_d;

  // rdy_q keeps output_ready low until the first edge after reset release.
  assign output_ready = rdy_q && (!output_valid || input_ready);
  assign accept       = input_valid && output_ready;
  assign auto_eff     = (state_q == S_IDLE) ? input_auto_j : mode_q;
  assign err_d        = range_err || frame_err;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    j_used    = input_j;
    last_d    = 1'b0;
    frame_err = 1'b0;
    if (auto_eff) begin
      j_used = '0;
      unique case (state_q)
        S_IDLE: begin
          if (input_first) begin
            if (ROUNDS == 1) begin
              last_d = 1'b1;
            end else if (accept) begin
              cnt_d   = J_W'(1);
              state_d = S_RUN;
            end
          end else begin
            frame_err = 1'b1;
          end
        end
        S_RUN: begin
          if (input_first) begin
            // Restart: this beat becomes round 0 of a fresh block.
            frame_err = 1'b1;
            if (accept) cnt_d = J_W'(1);
          end else begin
            j_used = cnt_q;
            if (32'(cnt_q) == ROUNDS - 1) begin
              last_d = 1'b1;
              if (accept) begin
                cnt_d   = '0;
                state_d = S_IDLE;
              end
            end else if (accept) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  sm3_ffgg_core #(
    .WORD_W(WORD_W),
    .ROUNDS(ROUNDS),
    .SPLIT (SPLIT),
    .J_W   (J_W)
  ) u_core (
    .x        (input_X),
    .y        (input_Y),
    .z        (input_Z),
    .j_used   (j_used),
    .ff       (ff_d),
    .gg       (gg_d),
    .range_err(range_err)
  );

`ifdef SM3_TJ_EN
  if (WORD_W != 32) begin : g_bad_width
    $error("sm3_ffgg_stream: SM3_TJ_EN requires WORD_W == 32");
  end

  logic [31:0] t_sel, tj_d;
  logic [63:0] t_dbl;
  logic [4:0]  rot;

  // Rotate by shifting a doubled copy; the upper half is the left rotation.
  always_comb begin
    t_sel = (32'(j_used) >= SPLIT) ? T_HI : T_LO;
    rot   = 5'(j_used);
    t_dbl = {t_sel, t_sel} << rot;
    tj_d  = err_d ? 32'h0 : t_dbl[63:32];
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      mode_q       <= 1'b0;
      rdy_q        <= 1'b0;
      output_valid <= 1'b0;
      output_ff    <= '0;
      output_gg    <= '0;
      output_j     <= '0;
      output_last  <= 1'b0;
      output_err   <= 1'b0;
`ifdef SM3_TJ_EN
      output_tj    <= '0;
`endif
    end else begin
      rdy_q   <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && state_q == S_IDLE) mode_q <= input_auto_j;
      if (accept) begin
        output_valid <= 1'b1;
        output_ff    <= ff_d;
        output_gg    <= gg_d;
        output_j     <= j_used;
        output_last  <= last_d;
        output_err   <= err_d;
`ifdef SM3_TJ_EN
        output_tj    <= WORD_W'(tj_d);
`endif
      end else if (input_ready) begin
        output_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm3_ffgg_stream.sv
// Directed bench for sm3_ffgg_stream with a scoreboard of expected results.
// Define SM3_TJ_EN for both bench and RTL to cover the T_j output.
module tb_sm3_ffgg_stream;

  localparam int          ROUNDS = 64;
  localparam int          SPLIT  = 16;
  localparam logic [31:0] X0 = 32'h0000FFFF;
  localparam logic [31:0] Y0 = 32'h00FF00FF;
  localparam logic [31:0] Z0 = 32'h0F0F0F0F;

  typedef struct {
    logic [31:0] ff;
    logic [31:0] gg;
    logic [31:0] tj;
    logic [5:0]  j;
    logic        last;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_first = 1'b0, in_auto = 1'b0, in_ready = 1'b0;
  logic [31:0] in_x = '0, in_y = '0, in_z = '0;
  logic [5:0]  in_j = '0;
  logic        out_ready, out_valid, out_last, out_err;
  logic [31:0] out_ff, out_gg;
  logic [5:0]  out_j;
`ifdef SM3_TJ_EN
  logic [31:0] out_tj;
`endif

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   accepts;
  bit   acc;

  always #5 clk = ~clk;

  sm3_ffgg_stream dut (
    .input_clk   (clk),
    .input_rst_n (rst_n),
    .input_valid (in_valid),
    .output_ready(out_ready),
    .input_X     (in_x),
    .input_Y     (in_y),
    .input_Z     (in_z),
    .input_j     (in_j),
    .input_first (in_first),
    .input_auto_j(in_auto),
    .output_valid(out_valid),
    .input_ready (in_ready),
    .output_ff   (out_ff),
    .output_gg   (out_gg),
    .output_j    (out_j),
    .output_last (out_last),
    .output_err  (out_err)
`ifdef SM3_TJ_EN
    ,
    .output_tj   (out_tj)
`endif
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, y, z, input logic [5:0] j,
                                 input logic last, input logic err);
    exp_t        e;
    logic [31:0] t;
    e.j    = j;
    e.last = last;
    e.err  = err;
    if (j < SPLIT) begin
      e.ff = x ^ y ^ z;
      e.gg = x ^ y ^ z;
      t    = 32'h79CC4519;
    end else begin
      e.ff = (x & y) | (x & z) | (y & z);
      e.gg = (x & y) | (~x & z);
      t    = 32'h7A879D8A;
    end
    e.tj = err ? 32'h0 : ((t << j[4:0]) | (t >> (6'd32 - {1'b0, j[4:0]})));
    return e;
  endfunction

  // One clock: drive at negedge, check/pop the current output, push if accepted.
  task automatic cycle(input logic v, input logic [31:0] x, y, z, input logic [5:0] j,
                       input logic first, input logic auto_j, input logic rdy,
                       input logic [5:0] ej, input logic el, input logic ee, output bit a);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_x = x; in_y = y; in_z = z; in_j = j;
    in_first = first; in_auto = auto_j; in_ready = rdy;
    #1;
    check("valid", out_valid, sb.size() != 0);
    if (out_valid && sb.size() != 0) begin
      e = sb[0];
      check("ff", out_ff, e.ff);
      check("gg", out_gg, e.gg);
      check("j", out_j, e.j);
      check("last", out_last, e.last);
      check("err", out_err, e.err);
`ifdef SM3_TJ_EN
      check("tj", out_tj, e.tj);
`endif
      if (!rdy) check("stall_ready", out_ready, 1'b0);
      else void'(sb.pop_front());
    end
    a = v && out_ready;
    if (a) sb.push_back(model(x, y, z, ej, el, ee));
    @(posedge clk);
  endtask

  task automatic beat(input logic [5:0] j, input logic first, input logic auto_j,
                      input logic [5:0] ej, input logic el, input logic ee);
    bit a;
    cycle(1'b1, X0 ^ {26'd0, ej}, Y0, Z0, j, first, auto_j, 1'b1, ej, el, ee, a);
    check("accept", a, 1'b1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", out_ready, 1'b0);
    check("rst_ff", out_ff, 32'h0);
    check("rst_gg", out_gg, 32'h0);
    check("rst_j", out_j, 6'd0);
    check("rst_last_err", {out_last, out_err}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_at_release", out_ready, 1'b0);

    // Manual mode, spec operands
    cycle(1'b1, X0, Y0, Z0, 6'd5, 1'b0, 1'b0, 1'b1, 6'd5, 1'b0, 1'b0, acc);
    #1;
    check("j5_ff", out_ff, 32'h0FF0F00F);
    check("j5_gg", out_gg, 32'h0FF0F00F);
    check("j5_err", out_err, 1'b0);
    cycle(1'b1, X0, Y0, Z0, 6'd20, 1'b0, 1'b0, 1'b1, 6'd20, 1'b0, 1'b0, acc);
    #1;
    check("j20_ff", out_ff, 32'h000F0FFF);
    check("j20_gg", out_gg, 32'h0F0F00FF);
    check("j20_j", out_j, 6'd20);
    cycle(1'b1, X0, Y0, Z0, 6'd63, 1'b1, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hFFFF0000, 32'h12345678, 32'hA5A5A5A5, 6'd15, 1'b0, 1'b0, 1'b1,
          6'd15, 1'b0, 1'b0, acc);
    cycle(1'b1, 32'hFFFF0000, 32'h12345678, 32'hA5A5A5A5, 6'd16, 1'b0, 1'b0, 1'b1,
          6'd16, 1'b0, 1'b0, acc);
`ifdef SM3_TJ_EN
    cycle(1'b1, X0, Y0, Z0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, acc);
    #1 check("tj0", out_tj, 32'h79CC4519);
    cycle(1'b1, X0, Y0, Z0, 6'd16, 1'b0, 1'b0, 1'b1, 6'd16, 1'b0, 1'b0, acc);
    #1 check("tj16", out_tj, 32'h9D8A7A87);
    cycle(1'b1, X0, Y0, Z0, 6'd33, 1'b0, 1'b0, 1'b1, 6'd33, 1'b0, 1'b0, acc);
    #1 check("tj33", out_tj, 32'hF50F3B14);
`endif

    // Auto block at full throughput: one accept per cycle
    accepts = 0;
    for (int b = 0; b < ROUNDS; b++) begin
      cycle(1'b1, X0 ^ b, Y0, Z0, 6'd0, b == 0, 1'b1, 1'b1, 6'(b), b == ROUNDS - 1, 1'b0, acc);
      if (acc) accepts++;
    end
    check("accepts_in_64_cycles", accepts, ROUNDS);

    // Back in idle: beat without first is a framing error at j=0
    beat(6'd9, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1);

    // Second block with a 3-cycle downstream stall mid-block
    for (int b = 0; b < ROUNDS; b++) begin
      if (b == 30) begin
        for (int s = 0; s < 3; s++) begin
          cycle(1'b1, X0 ^ 32'd30, Y0, Z0, 6'd0, 1'b0, 1'b1, 1'b0, 6'd30, 1'b0, 1'b0, acc);
          check("stall_no_accept", acc, 1'b0);
        end
      end
      beat(6'd0, b == 0, 1'b1, 6'(b), b == ROUNDS - 1, 1'b0);
    end

    // Third block: restart by first at position 10; manual request ignored while running
    for (int b = 0; b < 10; b++) beat(6'd0, b == 0, 1'b1, 6'(b), 1'b0, 1'b0);
    beat(6'd0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1);
    beat(6'd0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0);
    beat(6'd7, 1'b0, 1'b0, 6'd2, 1'b0, 1'b0);

    // Asynchronous reset mid-block
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_ready", out_ready, 1'b0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    beat(6'd0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b0);
    beat(6'd0, 1'b0, 1'b1, 6'd1, 1'b0, 1'b0);

    // Drain
    cycle(1'b0, '0, '0, '0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, acc);
    cycle(1'b0, '0, '0, '0, 6'd0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, acc);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sm3_ffgg_stream.md
Name: sm3_ffgg_stream

Overview:
- Streaming, parametrised successor to the SM3 GG boolean stage.
- Evaluates both SM3 boolean functions per beat:
  - FF_j = X^Y^Z for j < SPLIT, else majority(X,Y,Z).
  - GG_j = X^Y^Z for j < SPLIT, else (X&Y)|(~X&Z).
- One registered output stage with valid/ready handshake.
- Round index j comes from the port (manual mode) or from an internal round counter with block framing (auto mode). Sits between the message-expansion feed and the compression-round datapath.

Parameters:
- WORD_W, 32, word width of X/Y/Z and results.
- ROUNDS, 64, rounds per block; j range 0..ROUNDS-1.
- SPLIT, 16, first round using majority/choose functions; must be < ROUNDS.
- J_W, $clog2(ROUNDS), width of j fields (derived, do not override).

Ports:
- input_clk, in, 1, clock.
- input_rst_n, in, 1, asynchronous active-low reset.
- input_valid, in, 1, input beat valid.
- output_ready, out, 1, block can accept a beat.
- input_X / input_Y / input_Z, in, WORD_W, operands.
- input_j, in, J_W, round index (manual mode only).
- input_first, in, 1, beat is round 0 of a block (auto mode).
- input_auto_j, in, 1, 1 = internal counter supplies j; sampled only in S_IDLE.
- output_valid, out, 1, result valid.
- input_ready, in, 1, downstream accepts result.
- output_ff / output_gg, out, WORD_W, FF_j / GG_j.
- output_j, out, J_W, j used for this result.
- output_last, out, 1, result is round ROUNDS-1 of an auto-mode block.
- output_err, out, 1, out-of-range j or framing error on this beat.

Behaviour:
- Reset: asynchronous, active-low.
  - All outputs 0; output_ready becomes 1 the first cycle after reset release.
  - FSM to S_IDLE, j counter 0, mode register 0.
  - Reset mid-block discards the in-flight result.
- Handshake:
  - output_ready = !output_valid || input_ready.
  - Accept = input_valid && output_ready.
  - Latency 1 cycle: the accepted beat appears on the next edge.
  - Output registers hold stable while output_valid && !input_ready.
  - Accept and drain in the same cycle is allowed (full throughput).
- Mode register: loads input_auto_j on every accept in S_IDLE; holds while in S_RUN.
- FSM S_IDLE / S_RUN (auto mode only; manual mode stays in S_IDLE):
  - S_IDLE, accept with input_first=1 in auto mode: j_used = 0, counter := 1, go to S_RUN (if ROUNDS==1, stay in S_IDLE and set last).
  - S_IDLE, accept with input_first=0 in auto mode: j_used = 0, output_err=1, no state change.
  - S_RUN, accept: j_used = counter, counter := counter+1.
  - S_RUN, accept with j_used == ROUNDS-1: output_last=1, counter := 0, go to S_IDLE.
  - S_RUN, input_first=1: abandons the block, restarts at j=0, output_err=1 on that beat, stays in S_RUN.
- Manual mode: j_used = input_j; input_first ignored; output_last=0.
  - j_used >= ROUNDS (non-power-of-two ROUNDS): output_ff = output_gg = 0, output_err=1.
- Arithmetic: pure bitwise, WORD_W wide; no carries. output_j = j_used.

Optional Feature:
- Macro: SM3_TJ_EN.
- Defined:
  - Adds output port output_tj [WORD_W], registered with the other results.
  - output_tj = T_j rotated left by (j_used mod 32).
  - T_j = 32'h79CC4519 for j < SPLIT, else 32'h7A879D8A.
  - Zero when output_err.
  - Elaboration error if WORD_W != 32.
- Undefined: port absent; no rotator logic.

Decomposition:
- Package sm3_pkg holds:
  - T_LO / T_HI constants.
  - State enum (S_IDLE, S_RUN).
  - Functions sm3_ff and sm3_gg, WORD_W-generic via parameterised class static or fixed-32 plus generic wrapper.
- Sub-module sm3_ffgg_core: combinational FF/GG/error selection from (X, Y, Z, j_used). The top owns the FSM, counter and output register.

Test Plan:
- Manual, X=0x0000FFFF, Y=0x00FF00FF, Z=0x0F0F0F0F, j=5 -> ff=gg=0x0FF0F00F, err=0, one cycle later.
- Same operands, j=20 -> ff=0x000F0FFF, gg=0x0F0F00FF, output_j=20.
- Auto mode: 64 back-to-back beats, first on beat 0, input_ready=1 -> output_j 0..63, last only on j=63, FSM back to S_IDLE, 64 results in 64 cycles.
- Backpressure: input_ready=0 for 3 cycles mid-block -> output_ready=0, outputs frozen, no j skipped or duplicated.
- Auto-mode framing: beat without first in S_IDLE -> err=1, output_j=0; first asserted at j=10 -> err=1, that beat j=0.
- SM3_TJ_EN: j=0 -> tj=0x79CC4519; j=16 -> 0x9D8A7A87; j=33 -> 0xF50F3B14. Async reset asserted mid-block -> output_valid=0 immediately, next block starts at j=0.
